// File: rtl/cpu_loader.sv
// Stream-driven program loader: parses a header, writes instruction and data memories,
// then enables the CPU for a fixed cycle budget.
//
// state     | meaning
// IDLE      | waiting for start
// HDR_I     | receiving instruction count N_I
// HDR_D     | receiving data word count N_D
// HDR_R     | receiving run cycle budget
// LOAD_I    | receiving instruction words
// LOAD_D_LO | receiving low half of a data word
// LOAD_D_HI | receiving high half of a data word, then writing it
// RUN       | CPU enabled for the run budget
// DONE      | session complete, waiting for start to drop
// ERR       | header out of range, waiting for start to drop
module cpu_loader #(
  parameter int unsigned IMEM_WORDS = 512,
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_HDR_I     = 4'd1;
  localparam logic [3:0] S_HDR_D     = 4'd2;
  localparam logic [3:0] S_HDR_R     = 4'd3;
  localparam logic [3:0] S_LOAD_I    = 4'd4;
  localparam logic [3:0] S_LOAD_D_LO = 4'd5;
  localparam logic [3:0] S_LOAD_D_HI = 4'd6;
  localparam logic [3:0] S_RUN       = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;
  localparam logic [3:0] S_ERR       = 4'd9;

  logic [3:0]  state_q, state_d;
  logic [31:0] n_i_q, n_i_d;
  logic [31:0] n_d_q, n_d_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] run_cnt_q, run_cnt_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] addr_ext_q, addr_ext_d;
  logic [31:0] wdata_ext_q, wdata_ext_d;
  logic        wen_ext_q, wen_ext_d;
  logic [63:0] addr_ext_2_q, addr_ext_2_d;
  logic [63:0] wdata_ext_2_q, wdata_ext_2_d;
  logic        wen_ext_2_q, wen_ext_2_d;
  logic        cpu_enable_q, cpu_enable_d;
  logic        beat;

  assign s_ready = (state_q == S_HDR_I) || (state_q == S_HDR_D) || (state_q == S_HDR_R) ||
                   (state_q == S_LOAD_I) || (state_q == S_LOAD_D_LO) ||
                   (state_q == S_LOAD_D_HI);
  assign busy    = s_ready || (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign error   = (state_q == S_ERR);
  assign beat    = s_valid && s_ready;

  assign addr_ext    = addr_ext_q;
  assign wdata_ext   = wdata_ext_q;
  assign wen_ext     = wen_ext_q;
  assign ren_ext     = 1'b0;
  assign addr_ext_2  = addr_ext_2_q;
  assign wdata_ext_2 = wdata_ext_2_q;
  assign wen_ext_2   = wen_ext_2_q;
  assign ren_ext_2   = 1'b0;
  assign cpu_enable  = cpu_enable_q;

  always_comb begin
    state_d       = state_q;
    n_i_d         = n_i_q;
    n_d_d         = n_d_q;
    cnt_d         = cnt_q;
    run_cnt_d     = run_cnt_q;
    lo_d          = lo_q;
    addr_ext_d    = addr_ext_q;
    wdata_ext_d   = wdata_ext_q;
    wen_ext_d     = 1'b0;
    addr_ext_2_d  = addr_ext_2_q;
    wdata_ext_2_d = wdata_ext_2_q;
    wen_ext_2_d   = 1'b0;
    cpu_enable_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_HDR_I;
      S_HDR_I: if (beat) begin
        n_i_d   = s_data;
        state_d = (s_data > IMEM_WORDS) ? S_ERR : S_HDR_D;
      end
      S_HDR_D: if (beat) begin
        n_d_d   = s_data;
        state_d = (s_data > DMEM_WORDS) ? S_ERR : S_HDR_R;
      end
      S_HDR_R: if (beat) begin
        run_cnt_d = s_data;
        cnt_d     = 32'd0;
        if (n_i_q != 32'd0)      state_d = S_LOAD_I;
        else if (n_d_q != 32'd0) state_d = S_LOAD_D_LO;
        else                     state_d = S_RUN;
      end
      S_LOAD_I: if (beat) begin
        wen_ext_d   = 1'b1;
        addr_ext_d  = {30'b0, cnt_q, 2'b00};
        wdata_ext_d = s_data;
        cnt_d       = cnt_q + 32'd1;
        if (cnt_q + 32'd1 == n_i_q) begin
          cnt_d   = 32'd0;
          state_d = (n_d_q != 32'd0) ? S_LOAD_D_LO : S_RUN;
        end
      end
      S_LOAD_D_LO: if (beat) begin
        lo_d    = s_data;
        state_d = S_LOAD_D_HI;
      end
      S_LOAD_D_HI: if (beat) begin
        wen_ext_2_d   = 1'b1;
        addr_ext_2_d  = {29'b0, cnt_q, 3'b000};
        wdata_ext_2_d = {s_data, lo_q};
        cnt_d         = cnt_q + 32'd1;
        state_d       = (cnt_q + 32'd1 == n_d_q) ? S_RUN : S_LOAD_D_LO;
      end
      // cpu_enable is registered, so it trails RUN entry by one cycle and
      // stays high for exactly run_cnt cycles.
      S_RUN: begin
        if (run_cnt_q == 32'd0) begin
          state_d = S_DONE;
        end else begin
          cpu_enable_d = 1'b1;
          run_cnt_d    = run_cnt_q - 32'd1;
        end
      end
      S_DONE, S_ERR: if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q       <= S_IDLE;
      n_i_q         <= 32'd0;
      n_d_q         <= 32'd0;
      cnt_q         <= 32'd0;
      run_cnt_q     <= 32'd0;
      lo_q          <= 32'd0;
      addr_ext_q    <= 64'd0;
      wdata_ext_q   <= 32'd0;
      wen_ext_q     <= 1'b0;
      addr_ext_2_q  <= 64'd0;
      wdata_ext_2_q <= 64'd0;
      wen_ext_2_q   <= 1'b0;
      cpu_enable_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_i_q         <= n_i_d;
      n_d_q         <= n_d_d;
      cnt_q         <= cnt_d;
      run_cnt_q     <= run_cnt_d;
      lo_q          <= lo_d;
      addr_ext_q    <= addr_ext_d;
      wdata_ext_q   <= wdata_ext_d;
      wen_ext_q     <= wen_ext_d;
      addr_ext_2_q  <= addr_ext_2_d;
      wdata_ext_2_q <= wdata_ext_2_d;
      wen_ext_2_q   <= wen_ext_2_d;
      cpu_enable_q  <= cpu_enable_d;
    end
  end

endmodule

// File: doc/cpu_loader.md
CPU_LOADER -- requirements
Module: cpu_loader

Interface
REQ-001 Parameter IMEM_WORDS, default 512, meaning instruction memory capacity in 32-bit words.
REQ-002 Parameter DMEM_WORDS, default 1024, meaning data memory capacity in 64-bit words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 arst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  level; in IDLE, starts a load session.
REQ-006 s_valid / s_data / s_ready  input / input[31:0] / output  load stream; a beat transfers when s_valid && s_ready are high at a rising edge.
REQ-007 addr_ext[63:0], wen_ext, ren_ext, wdata_ext[31:0]  outputs  instruction memory external port.
REQ-008 addr_ext_2[63:0], wen_ext_2, ren_ext_2, wdata_ext_2[63:0]  outputs  data memory external port.
REQ-009 cpu_enable  output  1  drives the CPU enable input.
REQ-010 busy, done, error  outputs  1 each  session status.

Function
REQ-011 Stream format: word0 N_I (instruction count), word1 N_D (data word count), word2 RUN (cycle budget), then N_I instruction words, then N_D data words, each sent as two beats (low half, then high half).
REQ-012 FSM states: IDLE, HDR_I, HDR_D, HDR_R, LOAD_I, LOAD_D_LO, LOAD_D_HI, RUN, DONE, ERR.
REQ-013 IDLE -> HDR_I when start=1; other states ignore start, except DONE/ERR, which return to IDLE when start=0.
REQ-014 s_ready = 1 only in HDR_I, HDR_D, HDR_R, LOAD_I, LOAD_D_LO, LOAD_D_HI; 0 in all other states.
REQ-015 Accepting N_I > IMEM_WORDS or N_D > DMEM_WORDS -> ERR next cycle; no memory write occurs for that session.
REQ-016 After HDR_R: N_I>0 -> LOAD_I; else N_D>0 -> LOAD_D_LO; else RUN.
REQ-017 LOAD_I beat k (0-based) -> next cycle wen_ext=1 for exactly one cycle, addr_ext=4*k, wdata_ext=beat data.
REQ-018 LOAD_D_LO captures the low half; the LOAD_D_HI beat for word j -> next cycle wen_ext_2=1 for one cycle, addr_ext_2=8*j, wdata_ext_2={hi,lo}.
REQ-019 The transition out of a load phase occurs on acceptance of its last beat; count tracking uses 32-bit counters compared against N_I/N_D.
REQ-020 ren_ext and ren_ext_2 are held at 0 at all times.
REQ-021 addr/wdata outputs hold their last values when wen is 0.
REQ-022 RUN: cpu_enable=1 for exactly RUN consecutive cycles, then DONE; RUN=0 -> enters DONE with cpu_enable never asserted.
REQ-023 cpu_enable=0 in every state except RUN; wen_ext and wen_ext_2 are never 1 while cpu_enable=1, and never 1 simultaneously.
REQ-024 busy=1 in HDR_*, LOAD_*, RUN; done=1 only in DONE; error=1 only in ERR.
REQ-025 s_valid=0 stalls the FSM in its current state with no side effects; no timeout.
REQ-026 The last write pulse, issued in the cycle after the final beat, coincides with the first cycle of RUN; cpu_enable rises one cycle later.

Reset
REQ-027 arst=1 forces IDLE immediately and asynchronously; all outputs 0, including addresses and data; all counters 0.
REQ-028 Reset mid-session aborts it; no further wen pulses; the next session restarts from word0.

Verification
REQ-029 start; stream 2,0,0,0x00500093,0x00100113 -> wen_ext pulses at addr 0 then 4 with those data; then DONE, cpu_enable never 1.
REQ-030 stream 0,1,5, lo=0x89ABCDEF, hi=0x01234567 -> single wen_ext_2 at addr 0, wdata 0x0123456789ABCDEF; cpu_enable high exactly 5 cycles; done=1.
REQ-031 N_I=513 -> error=1, no wen pulses; dropping start returns to IDLE.
REQ-032 s_valid deasserted 3 cycles between beats -> s_ready stays 1, no extra or duplicated write, addresses contiguous.
REQ-033 arst pulse after second instruction beat -> outputs 0 immediately; a new session writes from addr 0.
REQ-034 N_I=IMEM_WORDS=512 -> final write at addr 2044, then RUN entered; no error.
